// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

    // Loader sequencing states
    typedef enum logic [3:0] {
        SYNC_WAIT,
        LEN_HI,
        LEN_LO,
        W0,
        W1,
        W2,
        WRITE,
        CSUM,
        ERR,
        RUN
    } boot_state_e;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned CSUM_W        = 8;

endpackage

// File: rtl/boot_byte_fetch.sv
// Pops one byte at a time from the show-ahead UART RX FIFO.
// The pop strobe is combinational so the head byte is consumed in the cycle it is popped.
module boot_byte_fetch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx_d_valid,
    input  logic [7:0] rx_rdata,
    output logic       rx_rd,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic armed;
    logic rd_prev;

    // Pop only when enabled, a byte is waiting and no pop happened last cycle.
    // armed keeps rx_rd low while reset is held.
    assign rx_rd      = armed & en & rx_d_valid & ~rd_prev;
    assign byte_valid = rx_rd;
    assign byte_data  = rx_rdata;

    // Remember last cycle's pop so two pops are never back to back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            armed   <= 1'b1;
            rd_prev <= rx_rd;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Power-up loader: owns SRAM port A, writes a framed image from the UART,
// verifies its checksum, then hands the port back and releases the J1.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned WIDTH          = 18,
    parameter int unsigned ADDR_W         = 13,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_d_valid,
    input  logic [7:0]        rx_rdata,
    output logic              rx_rd,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_wr,
    output logic              cpu_resetq,
    output logic              boot_busy,
    output logic              boot_done,
    output logic              boot_timeout,
    output logic              boot_err
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    boot_state_e       state, state_d;
    logic              fetch_en;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [31:0]       tcnt;
    logic              tmo_armed;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [15:0]       len_rx;
    logic [IDX_W-1:0]  idx;
    logic [CSUM_W-1:0] sum;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic              sync_hit;

    assign fetch_en = state inside {SYNC_WAIT, LEN_HI, LEN_LO, W0, W1, W2, CSUM};
    assign sync_hit = (state == SYNC_WAIT) && byte_valid && (byte_data == SYNC_BYTE);
    assign len_rx   = {len_hi, byte_data};

    boot_byte_fetch u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (fetch_en),
        .rx_d_valid (rx_d_valid),
        .rx_rdata   (rx_rdata),
        .rx_rd      (rx_rd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC_WAIT;
        else        state <= state_d;
    end

    // Next-state logic; a sync byte beats a same-cycle timeout
    always_comb begin
        state_d = state;
        case (state)
            SYNC_WAIT: begin
                if (sync_hit)
                    state_d = LEN_HI;
                else if (tmo_armed && (tcnt == 32'(TIMEOUT_CYCLES - 1)))
                    state_d = RUN;
            end
            LEN_HI: if (byte_valid) state_d = LEN_LO;
            LEN_LO: begin
                if (byte_valid) begin
                    if (len_rx == 16'd0)            state_d = CSUM;
                    else if (32'(len_rx) > DEPTH)   state_d = ERR;
                    else                            state_d = W0;
                end
            end
            W0:     if (byte_valid) state_d = W1;
            W1:     if (byte_valid) state_d = W2;
            W2:     if (byte_valid) state_d = WRITE;
            WRITE:  state_d = (32'(idx) + 32'd1 == 32'(len)) ? CSUM : W0;
            CSUM:   if (byte_valid) state_d = (byte_data == sum) ? RUN : ERR;
            ERR:    state_d = SYNC_WAIT;
            RUN:    state_d = RUN;
            default: state_d = SYNC_WAIT;
        endcase
    end

    // Datapath: timeout, length, word assembly, checksum and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt         <= '0;
            tmo_armed    <= 1'b1;
            len_hi       <= '0;
            len          <= '0;
            idx          <= '0;
            sum          <= '0;
            b0           <= '0;
            b1           <= '0;
            mem_own      <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wr       <= 1'b0;
            cpu_resetq   <= 1'b0;
            boot_busy    <= 1'b0;
            boot_done    <= 1'b0;
            boot_timeout <= 1'b0;
            boot_err     <= 1'b0;
        end else begin
            mem_wr <= 1'b0;

            if (sync_hit) begin
                tcnt      <= '0;
                tmo_armed <= 1'b0;
                boot_err  <= 1'b0;
                boot_busy <= 1'b1;
                sum       <= '0;
            end else if ((state == SYNC_WAIT) && tmo_armed) begin
                tcnt <= tcnt + 32'd1;
            end

            if (byte_valid) begin
                case (state)
                    LEN_HI: begin
                        len_hi <= byte_data;
                        sum    <= sum + byte_data;
                    end
                    LEN_LO: begin
                        len <= len_rx;
                        idx <= '0;
                        sum <= sum + byte_data;
                    end
                    W0: begin
                        b0  <= byte_data;
                        sum <= sum + byte_data;
                    end
                    W1: begin
                        b1  <= byte_data;
                        sum <= sum + byte_data;
                    end
                    W2: begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= ADDR_W'(idx);
                        mem_wdata <= WIDTH'({b0, b1, byte_data});
                        sum       <= sum + byte_data;
                    end
                    default: ;
                endcase
            end

            if (state == WRITE) idx <= idx + IDX_W'(1);

            if ((state_d == ERR) && (state != ERR)) begin
                boot_err  <= 1'b1;
                boot_busy <= 1'b0;
            end

            if ((state_d == RUN) && (state != RUN)) begin
                mem_own      <= 1'b0;
                boot_busy    <= 1'b0;
                boot_done    <= (state == CSUM);
                boot_timeout <= (state == SYNC_WAIT);
            end

            // CPU leaves reset one cycle after the SRAM port is handed back
            if ((state == RUN) && !mem_own) cpu_resetq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a show-ahead RX FIFO model.
module tb_uart_boot_loader;

    localparam int unsigned WIDTH  = 18;
    localparam int unsigned ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_d_valid = 1'b0;
    logic [7:0]        rx_rdata = 8'h00;
    logic              rx_rd;
    logic              mem_own;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_wr;
    logic              cpu_resetq;
    logic              boot_busy;
    logic              boot_done;
    logic              boot_timeout;
    logic              boot_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  fifo[$];
    logic        pop_req = 1'b0;
    logic        rd_prev_tb = 1'b0;
    int          rd_dup = 0;
    int          n_pop = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    uart_boot_loader #(
        .WIDTH          (WIDTH),
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_d_valid   (rx_d_valid),
        .rx_rdata     (rx_rdata),
        .rx_rd        (rx_rd),
        .mem_own      (mem_own),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .cpu_resetq   (cpu_resetq),
        .boot_busy    (boot_busy),
        .boot_done    (boot_done),
        .boot_timeout (boot_timeout),
        .boot_err     (boot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_upd();
        rx_d_valid = (fifo.size() != 0);
        rx_rdata   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // Pop strobe seen at the edge; back-to-back pops are counted as violations
    always @(posedge clk) begin
        if (rx_rd && rd_prev_tb) rd_dup++;
        if (rx_rd) n_pop++;
        rd_prev_tb <= rx_rd;
        pop_req    <= rx_rd;
    end

    // FIFO head advances half a cycle after the consuming edge; writes recorded
    always @(negedge clk) begin
        if (pop_req && (fifo.size() != 0)) begin
            void'(fifo.pop_front());
            fifo_upd();
        end
        if (mem_wr) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(32'(mem_wdata));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo.delete();
        fifo_upd();
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        rd_dup = 0;
        n_pop  = 0;
        rst_n  = 1'b1;
    endtask

    task automatic send(input logic [7:0] b[$]);
        @(negedge clk);
        foreach (b[k]) fifo.push_back(b[k]);
        fifo_upd();
    endtask

    // sel: 0 = boot_done, 1 = boot_err, 2 = boot_timeout
    task automatic wait_sig(input int sel, input int maxc, input string tag, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            hit = (sel == 0) ? boot_done : (sel == 1) ? boot_err : boot_timeout;
        end
        if (!hit) check({tag, "_wait_expired"}, 32'(cyc), 32'(maxc + 1));
    endtask

    task automatic build_frame(input int nw, output logic [7:0] f[$]);
        logic [7:0] s;
        f = {};
        f.push_back(8'hA5);
        f.push_back(8'(nw >> 8));
        f.push_back(8'(nw));
        for (int i = 0; i < nw; i++) begin
            f.push_back(8'(i));
            f.push_back(8'(8'h10 + i));
            f.push_back(8'(8'h20 + i));
        end
        s = 8'h00;
        for (int k = 1; k < f.size(); k++) s = s + f[k];
        f.push_back(s);
    endtask

    initial begin
        logic [7:0]  fr[$];
        logic [23:0] w24;
        int          cyc;

        // Watchdog
        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Idle RX: timeout boot
        do_reset();
        check("rst_mem_own", 32'(mem_own), 32'd1);
        check("rst_cpu_resetq", 32'(cpu_resetq), 32'd0);
        check("rst_busy", 32'(boot_busy), 32'd0);
        wait_sig(2, 1100, "tmo", cyc);
        check("tmo_cycle_in_window", 32'(cyc >= 999 && cyc <= 1001), 32'd1);
        check("tmo_mem_own", 32'(mem_own), 32'd0);
        check("tmo_cpu_held", 32'(cpu_resetq), 32'd0);
        check("tmo_done", 32'(boot_done), 32'd0);
        @(negedge clk);
        check("tmo_cpu_released", 32'(cpu_resetq), 32'd1);
        check("tmo_writes", 32'(wr_addr.size()), 32'd0);

        // Two-word frame, checksum 00+02+03+12+34+00+AB+CD = 0xC3
        do_reset();
        send('{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'hC3});
        wait_sig(0, 200, "ok2", cyc);
        check("ok2_done", 32'(boot_done), 32'd1);
        check("ok2_err", 32'(boot_err), 32'd0);
        check("ok2_writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("ok2_addr0", wr_addr[0], 32'd0);
            check("ok2_data0", wr_data[0], 32'h31234);
            check("ok2_addr1", wr_addr[1], 32'd1);
            check("ok2_data1", wr_data[1], 32'h0ABCD);
        end
        check("ok2_mem_own", 32'(mem_own), 32'd0);
        @(negedge clk);
        check("ok2_cpu", 32'(cpu_resetq), 32'd1);

        // Bad checksum, then a good frame
        do_reset();
        send('{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'hC4});
        wait_sig(1, 200, "bad", cyc);
        check("bad_err", 32'(boot_err), 32'd1);
        check("bad_done", 32'(boot_done), 32'd0);
        check("bad_writes", 32'(wr_addr.size()), 32'd2);
        repeat (3) @(negedge clk);
        check("bad_busy", 32'(boot_busy), 32'd0);
        check("bad_cpu", 32'(cpu_resetq), 32'd0);
        check("bad_mem_own", 32'(mem_own), 32'd1);
        send('{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'hC3});
        wait_sig(0, 200, "retry", cyc);
        check("retry_err", 32'(boot_err), 32'd0);
        check("retry_done", 32'(boot_done), 32'd1);
        check("retry_writes", 32'(wr_addr.size()), 32'd4);

        // Garbage before sync, zero-length frame
        do_reset();
        send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00});
        wait_sig(0, 200, "len0", cyc);
        check("len0_done", 32'(boot_done), 32'd1);
        check("len0_writes", 32'(wr_addr.size()), 32'd0);

        // Oversize length 0x2001
        do_reset();
        send('{8'hA5, 8'h20, 8'h01});
        wait_sig(1, 200, "big", cyc);
        check("big_err", 32'(boot_err), 32'd1);
        check("big_done", 32'(boot_done), 32'd0);
        check("big_writes", 32'(wr_addr.size()), 32'd0);

        // Reset during W1 of word 5 of an 8-word frame
        do_reset();
        build_frame(8, fr);
        send(fr);
        cyc = 0;
        while (n_pop < 19 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached_w1", 32'(n_pop), 32'd19);
        check("mid_busy_before", 32'(boot_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_mem_own", 32'(mem_own), 32'd1);
        check("mid_cpu", 32'(cpu_resetq), 32'd0);
        check("mid_busy", 32'(boot_busy), 32'd0);
        check("mid_wr", 32'(mem_wr), 32'd0);
        check("mid_addr", 32'(mem_addr), 32'd0);
        check("mid_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rx_rd", 32'(rx_rd), 32'd0);
        do_reset();
        send(fr);
        wait_sig(0, 400, "full8", cyc);
        check("full8_done", 32'(boot_done), 32'd1);
        check("full8_writes", 32'(wr_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            w24 = {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)};
            check($sformatf("full8_addr%0d", i), wr_addr[i], 32'(i));
            check($sformatf("full8_data%0d", i), wr_data[i], 32'(w24[17:0]));
        end
        check("full8_rd_back_to_back", 32'(rd_dup), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
